uart_rx: RTL and testbench
==========================

# uart_rx

Multi-word UART receiver; the receive-side counterpart of the team's `uart_tx` transmitter, sharing its framing parameters. It consumes a serial line, for example the looped-back or external TX line. It reassembles `WORD_COUNT` consecutive words into one parallel frame and presents the frame with a one-cycle valid strobe. Parity and stop-bit errors, glitched start bits and stalled partial frames are detected and the frame is discarded.

## Interface
- `CLK_RATE`, 10000000: clock frequency in Hz.
- `BAUD_RATE`, 115200: bit rate; `CLKDIV = CLK_RATE/BAUD_RATE`, integer division, minimum 4.
- `WORD_LEN`, 8: data bits per word; legal values 5 to 8.
- `WORD_COUNT`, 1: words per frame; legal values 1 to 255.
- `PARITY`, "L": "L" none, "M" even (bit = ^data), "N" odd (bit = ~^data).
- `STOP`, 1: stop bits; 1 or 2.
- `TIMEOUT`, 16: maximum idle gap between words of one frame, in bit periods.
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `rx_i`  in  1  serial input; asynchronous, idles high.
- `rx_data_o`  out  `WORD_COUNT*WORD_LEN`  last good frame; the first received word is in the most significant slice.
- `rx_valid_o`  out  1  one-cycle pulse when `rx_data_o` is updated.
- `rx_busy_o`  out  1  high from start-bit detection until the frame completes or is discarded.
- `rx_parity_err_o`  out  1  one-cycle pulse on parity mismatch.
- `rx_frame_err_o`  out  1  one-cycle pulse on a stop bit sampled low, or on a timeout.

## Operation
- `rx_i` passes through a 2-FF synchronizer; all logic uses the synchronized value `rx_s`.
- States:
  - IDLE: waits for `rx_s` to be 0.
  - START: counts `CLKDIV/2` cycles, then samples `rx_s`.
    - 1: glitch; returns to IDLE with no error flagged. If no word has been received yet in this frame, `rx_busy_o` falls.
    - 0: goes to DATA.
  - DATA: samples every `CLKDIV` cycles, LSB first, `WORD_LEN` bits. Goes to PARITY if `PARITY` is not "L", else to STOP.
  - PARITY: one sample, compared against the received data.
  - STOP: `STOP` samples, each required to be 1.
  - GAP: entered after a good word when more words are due. Waits for `rx_s`=0, which leads to START. After `TIMEOUT*CLKDIV` cycles with no start, it pulses `rx_frame_err_o` and goes to IDLE.
- Word assembly:
  - Each good word shifts into a frame shift register from the LSB end: `frame <= {frame, word}`.
  - A word counter counts from 0 to `WORD_COUNT-1`.
- Completion:
  - After the last stop sample of word `WORD_COUNT-1`, `rx_data_o` is loaded from the shift register and `rx_valid_o` pulses in the same cycle.
  - The state returns to IDLE and the word counter clears.
- Errors:
  - A parity or stop error pulses the matching flag in the cycle after the failing sample.
  - The partial frame is discarded, the word counter clears, and the state returns to IDLE.
  - `rx_data_o` keeps its previous value; `rx_valid_o` does not pulse.
  - A parity error still waits through the stop bits before returning to IDLE. Only one flag pulses per word; a parity error takes precedence.
- A stop-bit failure goes to IDLE immediately after the failing sample, so resynchronisation happens on the next falling edge.

## Timing
- Reset values:
  - `rx_data_o` = 0; `rx_valid_o`, `rx_busy_o`, `rx_parity_err_o`, `rx_frame_err_o` = 0.
  - State IDLE; all counters 0.
- Reset is asynchronous. Asserting it mid-frame aborts immediately and no flag pulses after release.
- Sampling: the n-th bit after the start bit is sampled `CLKDIV/2 + n*CLKDIV` cycles after the cycle in which START is entered.
- Latency, with N = 1 + `WORD_LEN` + (`PARITY` is not "L") + `STOP`:
  - `rx_valid_o` rises `CLKDIV/2 + (N-1)*CLKDIV + 1` cycles after START entry.
  - START entry is 2–3 cycles after the `rx_i` falling edge.
- Baud tolerance: ±4% at `CLKDIV` ≥ 16.
- `rx_busy_o` rises in the cycle START is entered. It falls together with the `rx_valid_o` or error pulse.
- The outputs have no back-pressure. Consumers must capture on `rx_valid_o`.

## Structure
- Package `uart_pkg` holds:
  - state encodings;
  - the parity codes "L"/"M"/"N";
  - the `CLKDIV` and counter-width functions, so they are shared with `uart_tx`.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with a reset value parameter, here 1. Reused by other asynchronous inputs.
- Bit timer, state machine and frame register stay in `uart_rx`.

## Test plan
All scenarios use CLK_RATE 10 MHz and BAUD 115200 (CLKDIV 86), with the bench driving `rx_i` directly.
- WORD_COUNT=2, PARITY "L": send 0xA5 then 0x3C -> one `rx_valid_o` pulse, `rx_data_o`=0xA53C, no error pulse.
- PARITY "M", STOP=2: send 0x5A with parity bit 1 (wrong) -> one `rx_parity_err_o` pulse, no valid, `rx_data_o` unchanged. Then send a correct 0x5A -> valid with 0x5A.
- Stop bit driven 0 on 0xFF -> `rx_frame_err_o` pulse. The next frame 0x00 is received correctly.
- 20-cycle low glitch on an idle line -> no pulses of any kind; `rx_busy_o` high for about 45 cycles, then low.
- WORD_COUNT=2: send 0x11, then idle 17 bit periods -> `rx_frame_err_o` at 16 bit periods. A following 0x22, 0x33 frame yields 0x2233.
- Assert `rst_ni` during DATA of the second word -> all outputs 0 during reset. A following complete frame is received normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity codes and
// divider/counter sizing helpers common to the transmit and receive sides.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } rx_state_e;

  localparam logic [7:0] PAR_NONE = "L";
  localparam logic [7:0] PAR_EVEN = "M";
  localparam logic [7:0] PAR_ODD  = "N";

  function automatic int uart_clkdiv(input int clk_rate, input int baud_rate);
    int div;
    div = clk_rate / baud_rate;
    return (div < 4) ? 4 : div;
  endfunction

  // Bits needed to hold the value max_val (never less than one).
  function automatic int uart_cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs, with a
// configurable reset value so idle-high lines come out of reset idle.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Multi-word UART receiver: assembles WORD_COUNT words into one frame and
// flags parity, stop-bit and inter-word timeout errors, discarding the frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int         CLK_RATE   = 10000000,
  parameter int         BAUD_RATE  = 115200,
  parameter int         WORD_LEN   = 8,
  parameter int         WORD_COUNT = 1,
  parameter logic [7:0] PARITY     = PAR_NONE,
  parameter int         STOP       = 1,
  parameter int         TIMEOUT    = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           rx_i,
  output logic [WORD_COUNT*WORD_LEN-1:0] rx_data_o,
  output logic                           rx_valid_o,
  output logic                           rx_busy_o,
  output logic                           rx_parity_err_o,
  output logic                           rx_frame_err_o
);

  localparam int CLKDIV  = uart_clkdiv(CLK_RATE, BAUD_RATE);
  localparam int TMO     = TIMEOUT * CLKDIV;
  localparam int TW      = uart_cnt_w(TMO);
  localparam int CW      = uart_cnt_w(WORD_COUNT);
  localparam int FW      = WORD_COUNT * WORD_LEN;
  localparam bit HAS_PAR = (PARITY != PAR_NONE);

  localparam logic [TW-1:0] HALF_T = TW'(CLKDIV / 2);
  localparam logic [TW-1:0] BIT_T  = TW'(CLKDIV - 1);
  localparam logic [TW-1:0] TMO_T  = TW'(TMO - 1);
  localparam logic [CW-1:0] LAST_W = CW'(WORD_COUNT - 1);
  localparam logic [3:0]    LAST_D = 4'(WORD_LEN - 1);
  localparam logic [3:0]    LAST_S = 4'(STOP - 1);

  logic                rx_s;
  rx_state_e           state;
  logic [TW-1:0]       timer;
  logic [3:0]          bit_cnt;
  logic [CW-1:0]       word_cnt;
  logic                par_bad;
  logic [WORD_LEN-1:0] word;
  logic [FW-1:0]       frame;
  logic [FW-1:0]       frame_next;
  logic                at_half;
  logic                at_bit;
  logic                par_exp;
  logic                word_done;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .d    (rx_i),
    .q    (rx_s)
  );

  assign at_half    = (timer == HALF_T);
  assign at_bit     = (timer == BIT_T);
  assign par_exp    = (PARITY == PAR_ODD) ? ~^word : ^word;
  assign frame_next = FW'({frame, word});
  // Last stop bit of a word that survived parity and stop checks.
  assign word_done  = (state == ST_STOP) && at_bit && rx_s &&
                      (bit_cnt == LAST_S) && !par_bad;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= ST_IDLE;
      timer           <= '0;
      bit_cnt         <= '0;
      word_cnt        <= '0;
      par_bad         <= 1'b0;
      rx_data_o       <= '0;
      rx_valid_o      <= 1'b0;
      rx_busy_o       <= 1'b0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
    end else begin
      rx_valid_o      <= 1'b0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
      timer           <= timer + 1'b1;
      unique case (state)
        ST_IDLE: begin
          timer <= '0;
          if (!rx_s) begin
            state     <= ST_START;
            rx_busy_o <= 1'b1;
          end
        end
        ST_START: if (at_half) begin
          timer <= '0;
          if (rx_s) begin
            state <= ST_IDLE;
            if (word_cnt == '0) rx_busy_o <= 1'b0;
          end else begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: if (at_bit) begin
          timer   <= '0;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_D) begin
            bit_cnt <= '0;
            state   <= HAS_PAR ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: if (at_bit) begin
          timer   <= '0;
          state   <= ST_STOP;
          par_bad <= (rx_s != par_exp);
          if (rx_s != par_exp) begin
            rx_parity_err_o <= 1'b1;
            rx_busy_o       <= 1'b0;
            word_cnt        <= '0;
          end
        end
        ST_STOP: if (at_bit) begin
          timer   <= '0;
          bit_cnt <= bit_cnt + 1'b1;
          // A low stop bit aborts at once so the next falling edge resyncs.
          if (!rx_s) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            par_bad   <= 1'b0;
            rx_busy_o <= 1'b0;
            if (!par_bad) rx_frame_err_o <= 1'b1;
          end else if (bit_cnt == LAST_S) begin
            bit_cnt <= '0;
            par_bad <= 1'b0;
            if (par_bad) begin
              state <= ST_IDLE;
            end else if (word_cnt == LAST_W) begin
              state      <= ST_IDLE;
              word_cnt   <= '0;
              rx_data_o  <= frame_next;
              rx_valid_o <= 1'b1;
              rx_busy_o  <= 1'b0;
            end else begin
              state    <= ST_GAP;
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (!rx_s) begin
            state <= ST_START;
            timer <= '0;
          end else if (timer == TMO_T) begin
            state          <= ST_IDLE;
            timer          <= '0;
            word_cnt       <= '0;
            rx_busy_o      <= 1'b0;
            rx_frame_err_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == ST_DATA && at_bit) word <= {rx_s, word[WORD_LEN-1:1]};
    if (word_done) frame <= frame_next;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: two instances (2-word no-parity, 1-word even
// parity with two stop bits) checked against a word/frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLKDIV = 86;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_a  = 1'b1;
  logic        rx_b  = 1'b1;
  logic [15:0] data_a;
  logic        valid_a, busy_a, perr_a, ferr_a;
  logic [7:0]  data_b;
  logic        valid_b, busy_b, perr_b, ferr_b;

  always #50 clk = ~clk;

  uart_rx #(
    .CLK_RATE(10000000), .BAUD_RATE(115200), .WORD_LEN(8), .WORD_COUNT(2),
    .PARITY("L"), .STOP(1), .TIMEOUT(16)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_a), .rx_data_o(data_a),
    .rx_valid_o(valid_a), .rx_busy_o(busy_a), .rx_parity_err_o(perr_a),
    .rx_frame_err_o(ferr_a)
  );

  uart_rx #(
    .CLK_RATE(10000000), .BAUD_RATE(115200), .WORD_LEN(8), .WORD_COUNT(1),
    .PARITY("M"), .STOP(2), .TIMEOUT(16)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_b), .rx_data_o(data_b),
    .rx_valid_o(valid_b), .rx_busy_o(busy_b), .rx_parity_err_o(perr_b),
    .rx_frame_err_o(ferr_b)
  );

  // Output event monitor
  int cyc = 0;
  int nval_a = 0, nperr_a = 0, nferr_a = 0, busy_cyc_a = 0, val_cyc_a = 0;
  int nval_b = 0, nperr_b = 0, nferr_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a) begin nval_a++; val_cyc_a = cyc; end
    if (perr_a)  nperr_a++;
    if (ferr_a)  nferr_a++;
    if (busy_a)  busy_cyc_a++;
    if (valid_b) nval_b++;
    if (perr_b)  nperr_b++;
    if (ferr_b)  nferr_b++;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got %0d cycles required < 95000", cyc);
    $fatal(1, "watchdog");
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: words in, frames/errors out
  logic [7:0]  pend_a[$];
  int          exp_val_a = 0, exp_ferr_a = 0;
  logic [15:0] exp_data_a = '0;
  int          exp_val_b = 0, exp_perr_b = 0, exp_ferr_b = 0;
  logic [7:0]  exp_data_b = '0;

  function automatic logic even_par(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) == 1;
  endfunction

  task automatic model_a(input logic [7:0] d, input bit stop_bad);
    if (stop_bad) begin
      exp_ferr_a++;
      pend_a.delete();
    end else begin
      pend_a.push_back(d);
      if (pend_a.size() == 2) begin
        exp_data_a = {pend_a[0], pend_a[1]};
        exp_val_a++;
        pend_a.delete();
      end
    end
  endtask

  task automatic model_b(input logic [7:0] d, input bit par_bad, input bit stop_bad);
    if (par_bad)       exp_perr_b++;
    else if (stop_bad) exp_ferr_b++;
    else begin
      exp_val_b++;
      exp_data_b = d;
    end
  endtask

  task automatic check_a(input string tag);
    check({tag, ".valid_a"}, nval_a, exp_val_a);
    check({tag, ".perr_a"},  nperr_a, 0);
    check({tag, ".ferr_a"},  nferr_a, exp_ferr_a);
    check({tag, ".data_a"},  data_a, exp_data_a);
    check({tag, ".busy_a"},  busy_a, (pend_a.size() != 0));
  endtask

  task automatic check_b(input string tag);
    check({tag, ".valid_b"}, nval_b, exp_val_b);
    check({tag, ".perr_b"},  nperr_b, exp_perr_b);
    check({tag, ".ferr_b"},  nferr_b, exp_ferr_b);
    check({tag, ".data_b"},  data_b, exp_data_b);
    check({tag, ".busy_b"},  busy_b, 0);
  endtask

  // Line drivers (all driven on the falling clock edge)
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic send_word(input int sel, input logic [7:0] d, input bit has_par,
                           input logic par, input bit stop_bad, input int per,
                           input int nstop);
    drive(sel, 1'b0);
    hold(per);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      hold(per);
    end
    if (has_par) begin
      drive(sel, par);
      hold(per);
    end
    for (int i = 0; i < nstop; i++) begin
      if (stop_bad && i == 0) begin
        drive(sel, 1'b0);
        hold((per * 3) / 4);
        drive(sel, 1'b1);
        hold(per - (per * 3) / 4);
      end else begin
        drive(sel, 1'b1);
        hold(per);
      end
    end
    drive(sel, 1'b1);
  endtask

  task automatic tx_a(input logic [7:0] d, input bit stop_bad, input int per);
    int v0, t0, lat;
    v0 = exp_val_a;
    t0 = cyc;
    send_word(0, d, 1'b0, 1'b0, stop_bad, per, 1);
    model_a(d, stop_bad);
    hold(CLKDIV);
    if (exp_val_a != v0) begin
      lat = val_cyc_a - t0;
      check("latency_a", (lat >= 820 && lat <= 821), 1);
    end
    check_a("word");
  endtask

  task automatic tx_b(input logic [7:0] d, input bit par_bad, input bit stop_bad,
                      input int per);
    send_word(1, d, 1'b1, even_par(d) ^ par_bad, stop_bad, per, 2);
    model_b(d, par_bad, stop_bad);
    hold(CLKDIV);
    check_b("word");
  endtask

  task automatic flush_a();
    if (pend_a.size() != 0) begin
      hold(17 * CLKDIV);
      exp_ferr_a++;
      pend_a.delete();
      check_a("flush");
    end
  endtask

  initial begin
    int b0;
    logic [7:0] d;
    bit sb, pb;
    int per;

    hold(5);
    check("rst.data_a", data_a, 0);
    check("rst.valid_a", valid_a, 0);
    check("rst.busy_a", busy_a, 0);
    check("rst.perr_a", perr_a, 0);
    check("rst.ferr_a", ferr_a, 0);
    check("rst.data_b", data_b, 0);
    check("rst.busy_b", busy_b, 0);
    rst_n = 1'b1;
    hold(4);

    tx_a(8'hA5, 1'b0, CLKDIV);
    tx_a(8'h3C, 1'b0, CLKDIV);

    b0 = busy_cyc_a;
    rx_a = 1'b0;
    hold(20);
    rx_a = 1'b1;
    hold(2 * CLKDIV);
    check("glitch.busy_len", ((busy_cyc_a - b0) >= 43 && (busy_cyc_a - b0) <= 46), 1);
    check_a("glitch");

    tx_a(8'h11, 1'b0, CLKDIV);
    hold(14 * CLKDIV);
    check_a("gap15");
    hold(2 * CLKDIV);
    exp_ferr_a++;
    pend_a.delete();
    check_a("gap17");
    tx_a(8'h22, 1'b0, CLKDIV);
    tx_a(8'h33, 1'b0, CLKDIV);

    tx_b(8'h5A, 1'b1, 1'b0, CLKDIV);
    tx_b(8'h5A, 1'b0, 1'b0, CLKDIV);
    tx_b(8'hFF, 1'b0, 1'b1, CLKDIV);
    tx_b(8'h00, 1'b0, 1'b0, CLKDIV);
    tx_b(8'hC3, 1'b1, 1'b1, CLKDIV);

    for (int f = 0; f < 12; f++) begin
      d   = 8'($urandom);
      sb  = ($urandom_range(0, 7) == 0);
      per = sb ? CLKDIV : int'($urandom_range(84, 88));
      tx_a(d, sb, per);
      hold(int'($urandom_range(0, 4)) * CLKDIV);
    end
    flush_a();

    for (int w = 0; w < 8; w++) begin
      d   = 8'($urandom);
      pb  = ($urandom_range(0, 3) == 0);
      sb  = ($urandom_range(0, 4) == 0);
      per = sb ? CLKDIV : int'($urandom_range(84, 88));
      tx_b(d, pb, sb, per);
    end

    tx_a(8'h44, 1'b0, CLKDIV);
    fork
      send_word(0, 8'h55, 1'b0, 1'b0, 1'b0, CLKDIV, 1);
      begin
        hold(4 * CLKDIV);
        rst_n = 1'b0;
        hold(2);
        check("rst_mid.data_a", data_a, 0);
        check("rst_mid.busy_a", busy_a, 0);
        check("rst_mid.valid_a", valid_a, 0);
        check("rst_mid.ferr_a", ferr_a, 0);
        check("rst_mid.data_b", data_b, 0);
      end
    join
    hold(CLKDIV);
    rst_n = 1'b1;
    pend_a.delete();
    exp_data_a = '0;
    exp_data_b = '0;
    hold(2 * CLKDIV);
    check_a("rst_after");
    check_b("rst_after");
    tx_a(8'h66, 1'b0, CLKDIV);
    tx_a(8'h77, 1'b0, CLKDIV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
